// File: rtl/ps2_key_event.sv
// ps2_key_event: turns the ps2_decoder byte stream into {ext, brk, code} key events.
// It tracks the modifier keys and queues events in a show-ahead FIFO. Optional IRQ: KEYEVT_IRQ_EN.
module ps2_key_event #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 code_in,
   input  logic                       code_valid,
   output logic [7:0]                 evt_code,
   output logic                       evt_ext,
   output logic                       evt_brk,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [$clog2(DEPTH+1)-1:0] evt_count,
   output logic                       overflow,
   input  logic                       overflow_clr,
   output logic                       mod_shift,
   output logic                       mod_ctrl,
   output logic                       mod_alt
`ifdef KEYEVT_IRQ_EN
   ,
   output logic                       irq,
   input  logic                       irq_clr
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [7:0] B_EXT    = 8'hE0;
   localparam logic [7:0] B_BRK    = 8'hF0;
   localparam logic [7:0] B_PAUSE  = 8'hE1;
   localparam logic [7:0] B_PAUSEK = 8'h77;

   // Modifier slots, one per physical key:
   // lshift, rshift, lctrl, rctrl, lalt, ralt (slot 0 is the lowest byte).
   localparam int         NMOD     = 6;
   localparam logic [47:0] MOD_CODE = 48'h11_11_14_14_59_12;
   localparam logic [5:0]  MOD_EXT  = 6'b101000;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXTBRK,
      PAUSE
   } state_t;

   state_t      state_reg, state_next;
   logic [2:0]  pause_cnt_reg, pause_cnt_next;

   logic        emit;
   logic        emit_ext;
   logic        emit_brk;
   logic [7:0]  emit_code;

   logic        is_noise;
   logic        is_fake_shift;

   assign is_noise      = code_in inside {8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
   assign is_fake_shift = (code_in == 8'h12) || (code_in == 8'h59);

   // ---------------------------------------------------------------
   // Prefix assembler
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         pause_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         pause_cnt_reg <= pause_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pause_cnt_next = pause_cnt_reg;
      emit           = 1'b0;
      emit_ext       = 1'b0;
      emit_brk       = 1'b0;
      emit_code      = code_in;
      if (code_valid) begin
         case (state_reg)
            IDLE: begin
               if (code_in == B_EXT) begin
                  state_next = EXT;
               end else if (code_in == B_BRK) begin
                  state_next = BRK;
               end else if (code_in == B_PAUSE) begin
                  state_next     = PAUSE;
                  pause_cnt_next = 3'd7;
               end else if (!is_noise) begin
                  emit = 1'b1;
               end
            end
            EXT: begin
               if (code_in == B_BRK) begin
                  state_next = EXTBRK;
               end else if (code_in == B_EXT) begin
                  state_next = EXT;
               end else begin
                  state_next = IDLE;
                  emit       = !is_fake_shift;
                  emit_ext   = 1'b1;
               end
            end
            BRK: begin
               state_next = IDLE;
               emit       = 1'b1;
               emit_brk   = 1'b1;
            end
            EXTBRK: begin
               state_next = IDLE;
               emit       = !is_fake_shift;
               emit_ext   = 1'b1;
               emit_brk   = 1'b1;
            end
            PAUSE: begin
               // The pause sequence carries no break code, so only a make is reported.
               pause_cnt_next = pause_cnt_reg - 3'd1;
               if (pause_cnt_reg <= 3'd1) begin
                  pause_cnt_next = '0;
                  state_next     = IDLE;
                  emit           = 1'b1;
                  emit_ext       = 1'b1;
                  emit_code      = B_PAUSEK;
               end
            end
            default: begin
               state_next     = IDLE;
               pause_cnt_next = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Modifier tracking: updates on every emit, whether or not the FIFO
   // accepts the event.
   // ---------------------------------------------------------------
   logic [NMOD-1:0] held_reg, held_next;

   genvar gi;
   generate
      for (gi = 0; gi < NMOD; gi++) begin : g_mod
         assign held_next[gi] =
            (emit && (emit_code == MOD_CODE[gi*8 +: 8]) && (emit_ext == MOD_EXT[gi]))
            ? !emit_brk : held_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         held_reg <= '0;
      end else begin
         held_reg <= held_next;
      end
   end

   assign mod_shift = held_reg[0] | held_reg[1];
   assign mod_ctrl  = held_reg[2] | held_reg[3];
   assign mod_alt   = held_reg[4] | held_reg[5];

   // ---------------------------------------------------------------
   // Show-ahead event FIFO
   // ---------------------------------------------------------------
   logic [9:0]       mem_reg [DEPTH];
   logic [DEPTH-1:0] wr_en;
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic             overflow_reg, overflow_next;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;
   logic [9:0]       push_word;
   logic [9:0]       head_word;

   assign full      = (count_reg == CW'(DEPTH));
   assign evt_valid = (count_reg != '0);
   assign pop       = evt_valid & evt_ready;
   assign push      = emit & (!full | pop);
   assign drop      = emit & full & !pop;
   assign push_word = {emit_ext, emit_brk, emit_code};

   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr
         assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) begin
            mem_reg[i] <= push_word;
         end
      end
   end

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
         overflow_next = 1'b1;
      end else if (overflow_clr) begin
         overflow_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   // Storage is not reset, so the head is masked while the FIFO is empty.
   assign head_word = mem_reg[rd_ptr_reg];
   assign evt_code  = evt_valid ? head_word[7:0] : 8'h00;
   assign evt_brk   = evt_valid & head_word[8];
   assign evt_ext   = evt_valid & head_word[9];
   assign evt_count = count_reg;
   assign overflow  = overflow_reg;

`ifdef KEYEVT_IRQ_EN
   logic irq_reg, irq_next;

   always_comb begin
      irq_next = irq_reg;
      if (push) begin
         irq_next = 1'b1;
      end else if (irq_clr) begin
         irq_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_reg <= 1'b0;
      end else begin
         irq_reg <= irq_next;
      end
   end

   assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_ps2_key_event.sv
// Testbench for ps2_key_event: a table of vectors, hand-written corner sequences,
// and randomized traffic checked against a behavioural model of events, held keys and the queue.
module tb_ps2_key_event;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    code_in;
   logic          code_valid;
   logic [7:0]    evt_code;
   logic          evt_ext;
   logic          evt_brk;
   logic          evt_valid;
   logic          evt_ready;
   logic [CW-1:0] evt_count;
   logic          overflow;
   logic          overflow_clr;
   logic          mod_shift;
   logic          mod_ctrl;
   logic          mod_alt;
   logic          irq_clr_drv;
`ifdef KEYEVT_IRQ_EN
   logic          irq;
`endif

   ps2_key_event #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .code_in      (code_in),
      .code_valid   (code_valid),
      .evt_code     (evt_code),
      .evt_ext      (evt_ext),
      .evt_brk      (evt_brk),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_count    (evt_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .mod_shift    (mod_shift),
      .mod_ctrl     (mod_ctrl),
      .mod_alt      (mod_alt)
`ifdef KEYEVT_IRQ_EN
      ,
      .irq          (irq),
      .irq_clr      (irq_clr_drv)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural reference: pending prefix bytes, pause bytes still to swallow,
   // a held flag for every (ext, code) key, and a queue of events.
   logic [9:0] m_q[$];
   logic [7:0] m_pfx[$];
   int         m_pause_left;
   bit         m_held[512];
   bit         m_ovf;
   bit         m_irq;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endtask

   function automatic bit pfx_has(input logic [7:0] x);
      foreach (m_pfx[i]) if (m_pfx[i] == x) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pfx.delete();
      m_pause_left = 0;
      foreach (m_held[i]) m_held[i] = 1'b0;
      m_ovf = 1'b0;
      m_irq = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] b, input logic v, input logic r,
                             input logic c, input logic ic);
      bit         em = 0, ex = 0, bk = 0, pushed = 0, dropped = 0;
      logic [7:0] cd = b;
      if (v) begin
         if (m_pause_left > 0) begin
            m_pause_left--;
            if (m_pause_left == 0) begin
               em = 1; ex = 1; cd = 8'h77;
            end
         end else if (m_pfx.size() == 0 && b == 8'hE1) begin
            m_pause_left = 7;
         end else if ((b == 8'hE0 || b == 8'hF0) && !pfx_has(8'hF0)) begin
            m_pfx.push_back(b);
         end else begin
            ex = pfx_has(8'hE0);
            bk = pfx_has(8'hF0);
            m_pfx.delete();
            if (!ex && !bk && (b inside {8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) em = 0;
            else if (ex && (b == 8'h12 || b == 8'h59)) em = 0;
            else em = 1;
         end
      end
      if (em) m_held[int'(ex) * 256 + int'(cd)] = !bk;
      if (r && m_q.size() > 0) void'(m_q.pop_front());
      if (em) begin
         if (m_q.size() < DEPTH) begin
            m_q.push_back({ex, bk, cd});
            pushed = 1;
         end else begin
            dropped = 1;
         end
      end
      if (dropped) m_ovf = 1'b1;
      else if (c)  m_ovf = 1'b0;
      if (pushed)  m_irq = 1'b1;
      else if (ic) m_irq = 1'b0;
   endtask

   function automatic logic [31:0] model_vec();
      logic [9:0] h = (m_q.size() > 0) ? m_q[0] : 10'h0;
      return {12'h0, m_q.size() > 0, 5'(m_q.size()), m_ovf,
              m_held[8'h12] | m_held[8'h59],
              m_held[8'h14] | m_held[256 + 8'h14],
              m_held[8'h11] | m_held[256 + 8'h11], h};
   endfunction

   function automatic logic [31:0] dut_vec();
      logic [9:0] h = evt_valid ? {evt_ext, evt_brk, evt_code} : 10'h0;
      return {12'h0, evt_valid, 5'(evt_count), overflow, mod_shift, mod_ctrl, mod_alt, h};
   endfunction

   task automatic drive(input logic [7:0] b, input logic v, input logic r,
                        input logic c, input logic ic);
      code_in = b; code_valid = v; evt_ready = r; overflow_clr = c; irq_clr_drv = ic;
      model_step(b, v, r, c, ic);
      @(posedge clk);
      #1;
      code_valid = 0; evt_ready = 0; overflow_clr = 0; irq_clr_drv = 0;
   endtask

   task automatic do_reset();
      reset = 1; code_valid = 0; evt_ready = 0; overflow_clr = 0; irq_clr_drv = 0;
      @(posedge clk);
      #1;
      reset = 0;
      model_reset();
   endtask

   typedef struct {
      logic [7:0] code;
      logic       v;
      logic       r;
      logic       ev;
      logic [7:0] ecode;
      logic       eext;
      logic       ebrk;
      int         ecnt;
      logic [2:0] emods;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [7:0] code, input logic v, input logic r, input logic ev,
                      input logic [7:0] ecode, input logic eext, input logic ebrk,
                      input int ecnt, input logic [2:0] emods);
      vec_t t;
      t.code = code; t.v = v; t.r = r; t.ev = ev; t.ecode = ecode;
      t.eext = eext; t.ebrk = ebrk; t.ecnt = ecnt; t.emods = emods;
      tbl.push_back(t);
   endtask

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 11))
         0:       return 8'hE0;
         1:       return 8'hF0;
         2:       return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
         3:       return 8'h12;
         4:       return 8'h59;
         5:       return 8'h14;
         6:       return 8'h11;
         7:       return 8'hFA;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      logic [31:0] exp_v;
      code_in = 8'h00; code_valid = 0; evt_ready = 0; overflow_clr = 0; irq_clr_drv = 0;
      reset = 1;
      model_reset();
      do_reset();

      check("reset_state", {12'h0, evt_valid, 5'(evt_count), overflow, mod_shift, mod_ctrl,
                            mod_alt, evt_ext, evt_brk, evt_code}, 32'h0);
`ifdef KEYEVT_IRQ_EN
      check("reset_irq", 32'(irq), 32'h0);
`endif

      // code, v, r | valid, head code, ext, brk, count, mods {shift,ctrl,alt}
      add(8'h1C, 1, 0, 1, 8'h1C, 0, 0, 1, 3'b000);
      add(8'hF0, 1, 0, 1, 8'h1C, 0, 0, 1, 3'b000);
      add(8'h1C, 1, 0, 1, 8'h1C, 0, 0, 2, 3'b000);
      add(8'h00, 0, 1, 1, 8'h1C, 0, 1, 1, 3'b000);
      add(8'hE0, 1, 1, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h75, 1, 0, 1, 8'h75, 1, 0, 1, 3'b000);
      add(8'hE0, 1, 0, 1, 8'h75, 1, 0, 1, 3'b000);
      add(8'hF0, 1, 0, 1, 8'h75, 1, 0, 1, 3'b000);
      add(8'h75, 1, 1, 1, 8'h75, 1, 1, 1, 3'b000);
      add(8'hE0, 1, 1, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h12, 1, 1, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'hE0, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h7C, 1, 0, 1, 8'h7C, 1, 0, 1, 3'b000);
      add(8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h12, 1, 0, 1, 8'h12, 0, 0, 1, 3'b100);
      add(8'h1C, 1, 0, 1, 8'h12, 0, 0, 2, 3'b100);
      add(8'hF0, 1, 0, 1, 8'h12, 0, 0, 2, 3'b100);
      add(8'h12, 1, 0, 1, 8'h12, 0, 0, 3, 3'b000);
      add(8'h00, 0, 1, 1, 8'h1C, 0, 0, 2, 3'b000);
      add(8'h00, 0, 1, 1, 8'h12, 0, 1, 1, 3'b000);
      add(8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'hE1, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h14, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h77, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'hE1, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'hF0, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h14, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'hF0, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h77, 1, 0, 1, 8'h77, 1, 0, 1, 3'b000);
      add(8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'h14, 1, 0, 1, 8'h14, 0, 0, 1, 3'b010);
      add(8'hE0, 1, 0, 1, 8'h14, 0, 0, 1, 3'b010);
      add(8'h11, 1, 0, 1, 8'h14, 0, 0, 2, 3'b011);
      add(8'hE0, 1, 1, 1, 8'h11, 1, 0, 1, 3'b011);
      add(8'hF0, 1, 0, 1, 8'h11, 1, 0, 1, 3'b011);
      add(8'h14, 1, 0, 1, 8'h11, 1, 0, 2, 3'b011);
      add(8'hF0, 1, 1, 1, 8'h14, 1, 1, 1, 3'b011);
      add(8'h14, 1, 0, 1, 8'h14, 1, 1, 2, 3'b001);
      add(8'hE0, 1, 1, 1, 8'h14, 0, 1, 1, 3'b001);
      add(8'hF0, 1, 0, 1, 8'h14, 0, 1, 1, 3'b001);
      add(8'h11, 1, 1, 1, 8'h11, 1, 1, 1, 3'b000);
      add(8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'hFA, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'hF0, 1, 0, 0, 8'h00, 0, 0, 0, 3'b000);
      add(8'hFA, 1, 0, 1, 8'hFA, 0, 1, 1, 3'b000);
      add(8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 3'b000);

      foreach (tbl[i]) begin
         drive(tbl[i].code, tbl[i].v, tbl[i].r, 1'b0, 1'b0);
         exp_v = {12'h0, tbl[i].ev, 5'(tbl[i].ecnt), 1'b0, tbl[i].emods,
                  tbl[i].ev ? {tbl[i].eext, tbl[i].ebrk, tbl[i].ecode} : 10'h0};
         check($sformatf("vec%0d", i), dut_vec(), exp_v);
         $display("vec %0d: byte=%h v=%0d r=%0d -> valid=%0d head=%0d/%0d/%h count=%0d mods=%b%b%b",
                  i, tbl[i].code, tbl[i].v, tbl[i].r, evt_valid, evt_ext, evt_brk, evt_code,
                  evt_count, mod_shift, mod_ctrl, mod_alt);
      end

      // evt_valid is still low in the cycle the first byte arrives
      do_reset();
      code_in = 8'h1C; code_valid = 1;
      model_step(8'h1C, 1, 0, 0, 0);
      #2;
      check("latency_before", 32'(evt_valid), 32'h0);
      @(posedge clk);
      #1;
      code_valid = 0;
      check("latency_after", {evt_valid, evt_code}, {1'b1, 8'h1C});
      $display("latency: valid after first byte=%0d", evt_valid);

      // Overflow, full-with-pop, clear priority and the optional interrupt
      do_reset();
      drive(8'h1C, 1, 0, 0, 0);
`ifdef KEYEVT_IRQ_EN
      check("irq_first_push", 32'(irq), 32'h1);
`endif
      drive(8'h32, 1, 0, 0, 0);
      drive(8'h21, 1, 0, 0, 0);
      drive(8'h23, 1, 0, 0, 0);
      check("full_no_ovf", {5'(evt_count), overflow}, {5'd4, 1'b0});
      drive(8'h24, 1, 0, 0, 0);
      check("overflow_set", {5'(evt_count), overflow, evt_code}, {5'd4, 1'b1, 8'h1C});
      drive(8'h12, 1, 0, 0, 0);
      check("mod_on_drop", {5'(evt_count), mod_shift, evt_code}, {5'd4, 1'b1, 8'h1C});
      drive(8'h2B, 1, 1, 0, 0);
      check("full_pop_push", {5'(evt_count), evt_code}, {5'd4, 8'h32});
      drive(8'h1A, 1, 0, 1, 0);
      check("drop_beats_clr", 32'(overflow), 32'h1);
      drive(8'h00, 0, 0, 1, 0);
      check("overflow_clr", 32'(overflow), 32'h0);
      $display("overflow seq: count=%0d overflow=%0d head=%h", evt_count, overflow, evt_code);
`ifdef KEYEVT_IRQ_EN
      drive(8'h00, 0, 1, 0, 0);
      drive(8'h2C, 1, 0, 0, 1);
      check("irq_push_vs_clr", 32'(irq), 32'h1);
      drive(8'h00, 0, 0, 0, 1);
      check("irq_clr", 32'(irq), 32'h0);
`endif

      // Reset in the middle of a prefix discards it
      do_reset();
      drive(8'hE0, 1, 0, 0, 0);
      do_reset();
      drive(8'h75, 1, 0, 0, 0);
      check("reset_mid_prefix", {evt_ext, evt_brk, evt_code, 5'(evt_count)},
            {1'b0, 1'b0, 8'h75, 5'd1});
      // Repeated E0 keeps the extended prefix
      drive(8'hE0, 1, 1, 0, 0);
      drive(8'hE0, 1, 0, 0, 0);
      drive(8'h75, 1, 0, 0, 0);
      check("e0_e0", {evt_ext, evt_brk, evt_code}, {1'b1, 1'b0, 8'h75});
      $display("prefix seq: head=%0d/%0d/%h", evt_ext, evt_brk, evt_code);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            drive(rand_byte(), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
         end
         check($sformatf("rand%0d", n), dut_vec(), model_vec());
`ifdef KEYEVT_IRQ_EN
         check($sformatf("rand_irq%0d", n), 32'(irq), 32'(m_irq));
`endif
      end
      $display("random: 3000 cycles applied");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
